// File: rtl/seven_seg_scan_driver.sv
// Multiplexed hex driver for N common-anode digits with LZ blanking, DP, PWM brightness and guard phase.
// Latency: one clock from scan state (slot_cnt/dig_idx) to AN/sevensegment; frame_start is registered.
// No backpressure: free-running scan; en=0 darkens outputs and freezes all scan state.
module seven_seg_scan_driver #(
  parameter int N_DIGITS = 8,
  parameter int DIV_LOG2 = 14
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    en,
  input  logic [4*N_DIGITS-1:0]   value,
  input  logic [N_DIGITS-1:0]     dp_mask,
  input  logic                    lz_en,
  input  logic [3:0]              brightness,
  output logic [7:0]              sevensegment,
  output logic [N_DIGITS-1:0]     AN,
  output logic                    frame_start
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);

  logic [DIV_LOG2-1:0]   slot_cnt;
  logic [IDX_W-1:0]      dig_idx;
  logic [4*N_DIGITS-1:0] value_sh;
  logic [N_DIGITS-1:0]   dp_sh;
  logic                  lz_sh;

  logic                  slot_wrap;
  logic                  frame_wrap;
  logic [3:0]            phase;
  logic [3:0]            cur_digit;
  logic                  blank;
  logic [7:0]            seg_code;
  logic [N_DIGITS-1:0]   an_nxt;
  logic [7:0]            seg_nxt;

  // Active-low segment pattern for one hex nibble; bit 7 (dp) left unlit.
  function automatic logic [7:0] hex_decode(input logic [3:0] d);
    case (d)
      4'h0: hex_decode = 8'hC0;
      4'h1: hex_decode = 8'hF9;
      4'h2: hex_decode = 8'hA4;
      4'h3: hex_decode = 8'hB0;
      4'h4: hex_decode = 8'h99;
      4'h5: hex_decode = 8'h92;
      4'h6: hex_decode = 8'h82;
      4'h7: hex_decode = 8'hF8;
      4'h8: hex_decode = 8'h80;
      4'h9: hex_decode = 8'h90;
      4'hA: hex_decode = 8'h88;
      4'hB: hex_decode = 8'h83;
      4'hC: hex_decode = 8'hC6;
      4'hD: hex_decode = 8'hA1;
      4'hE: hex_decode = 8'h86;
      default: hex_decode = 8'h8E;
    endcase
  endfunction

  assign slot_wrap  = &slot_cnt;
  assign frame_wrap = slot_wrap && (dig_idx == LAST_IDX);
  assign phase      = slot_cnt[DIV_LOG2-1 -: 4];

  // Decode the current slot from shadow state; phase 0 is the guard where seg data may switch digit.
  always_comb begin
    an_nxt    = '1;
    cur_digit = value_sh[{dig_idx, 2'b00} +: 4];
    blank     = lz_sh && (dig_idx != '0) && ((value_sh >> {dig_idx, 2'b00}) == '0);
    seg_code  = hex_decode(cur_digit);
    seg_nxt   = {~dp_sh[dig_idx], (blank ? 7'h7F : seg_code[6:0])};
    if ((phase != 4'd0) && (phase <= brightness)) begin
      an_nxt[dig_idx] = 1'b0;
    end
  end

  // Scan counters: slot timer and digit index, frozen while disabled.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slot_cnt <= '0;
      dig_idx  <= '0;
    end else if (en) begin
      slot_cnt <= slot_cnt + 1'b1;
      if (frame_wrap) begin
        dig_idx <= '0;
      end else if (slot_wrap) begin
        dig_idx <= dig_idx + 1'b1;
      end
    end
  end

  // Frame snapshot of display content so a scan never mixes old and new values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      value_sh <= '0;
      dp_sh    <= '0;
      lz_sh    <= 1'b0;
    end else if (en && frame_wrap) begin
      value_sh <= value;
      dp_sh    <= dp_mask;
      lz_sh    <= lz_en;
    end
  end

  // Registered pin drivers; reset and disable both force the display dark.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      AN           <= '1;
      sevensegment <= 8'hFF;
      frame_start  <= 1'b0;
    end else if (en) begin
      AN           <= an_nxt;
      sevensegment <= seg_nxt;
      frame_start  <= frame_wrap;
    end else begin
      AN           <= '1;
      sevensegment <= 8'hFF;
      frame_start  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
module tb_seven_seg_scan_driver;

  logic        clock = 1'b0;
  logic        reset;
  logic        en;
  logic [15:0] value;
  logic [3:0]  dp_mask;
  logic        lz_en;
  logic [3:0]  brightness;
  logic [7:0]  sevensegment;
  logic [3:0]  AN;
  logic        frame_start;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  seven_seg_scan_driver #(.N_DIGITS(4), .DIV_LOG2(4)) dut (
    .clock(clock), .reset(reset), .en(en), .value(value), .dp_mask(dp_mask),
    .lz_en(lz_en), .brightness(brightness), .sevensegment(sevensegment),
    .AN(AN), .frame_start(frame_start)
  );

  always #5 clock = ~clock;

  localparam logic [7:0] HEX [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Reference model: t counts enabled cycles since reset; slot = 16 cycles, frame = 64 cycles.
  int          t;
  logic [15:0] m_val;
  logic [3:0]  m_dp;
  logic        m_lz;
  logic [3:0]  e_an;
  logic [7:0]  e_seg;
  logic        e_fs;

  always @(posedge clock or posedge reset) begin
    int ph, d;
    logic [3:0] nib;
    logic blk;
    if (reset) begin
      t = 0; m_val = 16'h0; m_dp = 4'h0; m_lz = 1'b0;
      e_an = 4'hF; e_seg = 8'hFF; e_fs = 1'b0;
    end else if (!en) begin
      e_an = 4'hF; e_seg = 8'hFF; e_fs = 1'b0;
    end else begin
      ph  = t % 16;
      d   = (t / 16) % 4;
      nib = 4'((m_val >> (4 * d)) & 16'hF);
      blk = m_lz && (d > 0) && ((m_val >> (4 * d)) == 16'h0);
      e_an = 4'hF;
      if (ph != 0 && ph <= int'(brightness)) e_an[d] = 1'b0;
      e_seg = blk ? {~m_dp[d], 7'h7F} : {~m_dp[d], HEX[nib][6:0]};
      e_fs  = (t % 64) == 63;
      if (e_fs) begin
        m_val = value; m_dp = dp_mask; m_lz = lz_en;
      end
      t = t + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clock) begin
    if (chk_on) begin
      chk("model_an",  {28'h0, AN}, {28'h0, e_an});
      chk("model_seg", {24'h0, sevensegment}, {24'h0, e_seg});
      chk("model_fs",  {31'h0, frame_start}, {31'h0, e_fs});
    end
  end

  task automatic wait_fs();
    bit found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      @(negedge clock);
      found = frame_start;
    end
    chk("wait_frame_start", {31'h0, found}, 32'h1);
  endtask

  int         lows [4];
  logic [7:0] seen [4];

  // Observe one full frame window starting on a frame_start cycle.
  task automatic sample_frame();
    wait_fs();
    for (int i = 0; i < 4; i++) begin lows[i] = 0; seen[i] = 8'hFF; end
    for (int k = 0; k < 64; k++) begin
      for (int i = 0; i < 4; i++) begin
        if (AN[i] == 1'b0) begin lows[i]++; seen[i] = sevensegment; end
      end
      @(negedge clock);
    end
  endtask

  task automatic check_frame(input string name, input int lo,
                             input logic [7:0] s0, input logic [7:0] s1,
                             input logic [7:0] s2, input logic [7:0] s3);
    logic [7:0] es [4];
    es[0] = s0; es[1] = s1; es[2] = s2; es[3] = s3;
    sample_frame();
    for (int i = 0; i < 4; i++) begin
      chk({name, "_lows"}, lows[i], lo);
      if (lo > 0) chk({name, "_seg"}, {24'h0, seen[i]}, {24'h0, es[i]});
    end
  endtask

  initial begin
    int fs_cnt;
    bit found;
    reset = 1'b1; en = 1'b0; value = 16'h0; dp_mask = 4'h0; lz_en = 1'b0; brightness = 4'd15;
    repeat (2) @(negedge clock);
    chk("reset_an",  {28'h0, AN}, 32'hF);
    chk("reset_seg", {24'h0, sevensegment}, 32'hFF);
    chk("reset_fs",  {31'h0, frame_start}, 32'h0);
    reset = 1'b0; en = 1'b1; chk_on = 1'b1;

    // Plain hex decode, full brightness.
    value = 16'h12A0;
    wait_fs();
    check_frame("t1", 15, 8'hC0, 8'h88, 8'hA4, 8'hF9);

    // Leading-zero blanking and decimal point.
    value = 16'h0005; lz_en = 1'b1; dp_mask = 4'b0100;
    wait_fs();
    check_frame("t2a", 15, 8'h92, 8'hFF, 8'h7F, 8'hFF);
    value = 16'h0000; dp_mask = 4'b0000;
    wait_fs();
    check_frame("t2b", 15, 8'hC0, 8'hFF, 8'hFF, 8'hFF);

    // Brightness PWM.
    brightness = 4'd0;
    check_frame("t3_dark", 0, 8'h0, 8'h0, 8'h0, 8'h0);
    brightness = 4'd3;
    check_frame("t3_b3", 3, 8'hC0, 8'hFF, 8'hFF, 8'hFF);

    // Mid-frame value change only shows after the next snapshot; one pulse per 64 cycles.
    brightness = 4'd15; lz_en = 1'b0;
    wait_fs();
    fs_cnt = 0;
    for (int k = 1; k <= 256; k++) begin
      @(negedge clock);
      if (k == 20) value = 16'h5678;
      if (frame_start) fs_cnt++;
    end
    chk("t4_fs_count", fs_cnt, 4);
    check_frame("t4", 15, 8'h80, 8'hF8, 8'h82, 8'h92);

    // Asynchronous reset between edges.
    repeat (21) @(negedge clock);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk("t5_async_an",  {28'h0, AN}, 32'hF);
    chk("t5_async_seg", {24'h0, sevensegment}, 32'hFF);
    @(negedge clock);
    reset = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 64 && !found; k++) begin
      @(negedge clock);
      found = (AN != 4'hF);
    end
    chk("t5_first_found", {31'h0, found}, 32'h1);
    chk("t5_first_an",  {28'h0, AN}, 32'hE);
    chk("t5_first_seg", {24'h0, sevensegment}, 32'hC0);

    // Enable hold for 40 cycles mid-slot.
    repeat (37) @(negedge clock);
    en = 1'b0;
    fs_cnt = 0; found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (frame_start) fs_cnt++;
      if (AN != 4'hF) found = 1'b1;
    end
    chk("t6_no_fs", fs_cnt, 0);
    chk("t6_dark", {31'h0, found}, 32'h0);
    en = 1'b1;

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      @(negedge clock);
      if ($urandom_range(0, 49) == 0) begin
        value   = 16'($urandom);
        if ($urandom_range(0, 1) == 0) value = value & 16'h00FF;
        dp_mask = 4'($urandom);
        lz_en   = 1'($urandom);
      end
      if ($urandom_range(0, 29) == 0) brightness = 4'($urandom);
      if ($urandom_range(0, 99) == 0) en = ~en;
    end
    en = 1'b1;
    repeat (4) @(negedge clock);
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
